// File: rtl/is_uart_rx_buf.sv
// Receive buffer between the UART RX FSM and its consumer: a show-ahead FIFO
// of 10-bit words (frame error, parity error, data) with overrun and error counting.
module is_uart_rx_buf #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          rx_data_en_i,
    input  logic [9:0]    rx_data_t_i,
    input  logic          rd_ready_i,
    output logic          rd_valid_o,
    output logic [7:0]    rd_data_o,
    output logic          rd_perr_o,
    output logic          rd_ferr_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          ovr_o,
    input  logic          ovr_clr_i,
    output logic [7:0]    err_cnt_o,
    input  logic          err_clr_i
);

    localparam int AW = $clog2(DEPTH);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          pop;
    logic          push;
    logic          rx_err;

    // A pop frees a slot on the same edge, so a full buffer can still accept a word.
    assign pop    = ~empty_q & rd_ready_i;
    assign push   = rx_data_en_i & (~full_q | pop);
    assign rx_err = rx_data_t_i[9] | rx_data_t_i[8];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_comb begin
        ovr_d = ovr_q;
        if (rx_data_en_i && full_q && !pop) begin
            ovr_d = 1'b1;
        end else if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
    end

    // Dropped words still count as errors; clear takes priority over increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr_i) begin
            err_cnt_d = '0;
        end else if (rx_data_en_i && rx_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovr_q     <= ovr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data_t_i;
        end
    end

    assign rd_valid_o = ~empty_q;
    assign rd_data_o  = mem_q[rd_ptr_q][7:0];
    assign rd_perr_o  = mem_q[rd_ptr_q][8];
    assign rd_ferr_o  = mem_q[rd_ptr_q][9];
    assign count_o    = count_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign ovr_o      = ovr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_is_uart_rx_buf.sv
// Scoreboard bench for is_uart_rx_buf: a queue-based reference model tracks expected
// contents and flags, and a negedge monitor compares every read handshake and status.
module tb_is_uart_rx_buf;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          rx_data_en_i = 1'b0;
    logic [9:0]    rx_data_t_i = '0;
    logic          rd_ready_i = 1'b0;
    logic          rd_valid_o;
    logic [7:0]    rd_data_o;
    logic          rd_perr_o;
    logic          rd_ferr_o;
    logic [CW-1:0] count_o;
    logic          empty_o;
    logic          full_o;
    logic          ovr_o;
    logic          ovr_clr_i = 1'b0;
    logic [7:0]    err_cnt_o;
    logic          err_clr_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: the expected FIFO contents in arrival order plus sticky flags.
    logic [9:0] sb_q[$];
    int         model_count = 0;
    bit         model_ovr = 1'b0;
    int         model_err = 0;

    is_uart_rx_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rx_data_en_i(rx_data_en_i),
        .rx_data_t_i (rx_data_t_i),
        .rd_ready_i  (rd_ready_i),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_perr_o   (rd_perr_o),
        .rd_ferr_o   (rd_ferr_o),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .ovr_o       (ovr_o),
        .ovr_clr_i   (ovr_clr_i),
        .err_cnt_o   (err_cnt_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the edge that consumed them.
    task automatic applyStimulus(input bit en, input logic [9:0] d, input bit rdy,
                                 input bit oclr, input bit eclr);
        rx_data_en_i = en;
        rx_data_t_i  = d;
        rd_ready_i   = rdy;
        ovr_clr_i    = oclr;
        err_clr_i    = eclr;
        @(posedge clk_i);
        #1;
    endtask

    // Model update: FIFO semantics from the buffer's rules, no knowledge of DUT internals.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sb_q.delete();
            model_count = 0;
            model_ovr   = 1'b0;
            model_err   = 0;
        end else begin
            bit m_pop;
            bit m_push;
            m_pop  = (model_count > 0) && rd_ready_i;
            m_push = rx_data_en_i && ((model_count < DEPTH) || m_pop);
            if (m_push) sb_q.push_back(rx_data_t_i);
            model_count = model_count + int'(m_push) - int'(m_pop);
            if (rx_data_en_i && (model_count == DEPTH) && !m_push && !m_pop) model_ovr = 1'b1;
            else if (ovr_clr_i) model_ovr = 1'b0;
            if (err_clr_i) model_err = 0;
            else if (rx_data_en_i && (rx_data_t_i[9] || rx_data_t_i[8]) && model_err < 255)
                model_err = model_err + 1;
        end
    end

    // Monitor: at each negedge compare status, and pop the scoreboard on a read handshake.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            checkOutput("count", 32'(count_o), 32'(model_count));
            checkOutput("empty", 32'(empty_o), 32'(model_count == 0));
            checkOutput("full", 32'(full_o), 32'(model_count == DEPTH));
            checkOutput("valid", 32'(rd_valid_o), 32'(model_count != 0));
            checkOutput("ovr", 32'(ovr_o), 32'(model_ovr));
            checkOutput("err_cnt", 32'(err_cnt_o), 32'(model_err));
            if (rd_valid_o && rd_ready_i) begin
                if (sb_q.size() == 0) begin
                    checkOutput("pop_on_empty_scoreboard", 32'(1), 32'(0));
                end else begin
                    logic [9:0] w;
                    w = sb_q.pop_front();
                    checkOutput("rd_data", 32'(rd_data_o), 32'(w[7:0]));
                    checkOutput("rd_perr", 32'(rd_perr_o), 32'(w[8]));
                    checkOutput("rd_ferr", 32'(rd_ferr_o), 32'(w[9]));
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_empty", 32'(empty_o), 32'(1));
        checkOutput("reset_count", 32'(count_o), 32'(0));
        checkOutput("reset_valid", 32'(rd_valid_o), 32'(0));
        checkOutput("reset_err", 32'(err_cnt_o), 32'(0));
        rstn_i = 1'b1;
        applyStimulus(0, 10'h000, 0, 0, 0);

        // Two words, then a pop reveals the second with its parity flag.
        applyStimulus(1, 10'h0A5, 0, 0, 0);
        applyStimulus(1, 10'h13C, 0, 0, 0);
        checkOutput("two_count", 32'(count_o), 32'(2));
        checkOutput("two_head", 32'(rd_data_o), 32'h A5);
        checkOutput("two_perr", 32'(rd_perr_o), 32'(0));
        checkOutput("two_ferr", 32'(rd_ferr_o), 32'(0));
        applyStimulus(0, 10'h000, 1, 0, 0);
        checkOutput("second_head", 32'(rd_data_o), 32'h3C);
        checkOutput("second_perr", 32'(rd_perr_o), 32'(1));
        checkOutput("second_ferr", 32'(rd_ferr_o), 32'(0));
        applyStimulus(0, 10'h000, 1, 0, 0);
        checkOutput("drained", 32'(empty_o), 32'(1));

        // Nine pushes into an eight-deep buffer: the last is lost.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 10'(i), 0, 0, 0);
            if (i == 7) checkOutput("full_after_8", 32'(full_o), 32'(1));
        end
        checkOutput("ovr_after_9", 32'(ovr_o), 32'(1));
        checkOutput("count_after_9", 32'(count_o), 32'(8));
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_order", 32'(rd_data_o), 32'(i));
            applyStimulus(0, 10'h000, 1, 0, 0);
        end
        checkOutput("drain_empty", 32'(empty_o), 32'(1));
        applyStimulus(0, 10'h000, 0, 1, 0);
        checkOutput("ovr_cleared", 32'(ovr_o), 32'(0));

        // Full buffer with simultaneous push and pop keeps count and raises no overrun.
        for (int i = 0; i < 8; i++) applyStimulus(1, 10'(8'h10 + i), 0, 0, 0);
        applyStimulus(1, 10'h055, 1, 0, 0);
        checkOutput("full_pushpop_count", 32'(count_o), 32'(8));
        checkOutput("full_pushpop_ovr", 32'(ovr_o), 32'(0));
        for (int i = 0; i < 8; i++) begin
            if (i == 7) checkOutput("last_is_55", 32'(rd_data_o), 32'h55);
            applyStimulus(0, 10'h000, 1, 0, 0);
        end

        // Single word through an always-ready consumer is visible for one cycle.
        applyStimulus(1, 10'h0FF, 1, 0, 0);
        checkOutput("ff_valid", 32'(rd_valid_o), 32'(1));
        checkOutput("ff_data", 32'(rd_data_o), 32'hFF);
        applyStimulus(0, 10'h000, 1, 0, 0);
        checkOutput("ff_gone", 32'(rd_valid_o), 32'(0));
        checkOutput("ff_count", 32'(count_o), 32'(0));

        // Error counter saturation, then clear beating a concurrent increment.
        for (int i = 0; i < 300; i++)
            applyStimulus(1, (i % 2 == 0) ? 10'(10'h200 | (i & 8'hFF)) : 10'(10'h100 | (i & 8'hFF)), 1, 0, 0);
        applyStimulus(0, 10'h000, 1, 0, 0);
        checkOutput("err_saturated", 32'(err_cnt_o), 32'd255);
        applyStimulus(1, 10'h300, 1, 0, 1);
        checkOutput("err_clear_wins", 32'(err_cnt_o), 32'(0));
        applyStimulus(0, 10'h000, 1, 0, 0);

        // Pointer wrap, then asynchronous reset with words stored.
        for (int i = 0; i < 20; i++) applyStimulus(1, 10'($urandom_range(0, 255)), 1, 0, 0);
        applyStimulus(0, 10'h000, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 10'(8'hC0 + i), 0, 0, 0);
        checkOutput("pre_reset_count", 32'(count_o), 32'(3));
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("async_empty", 32'(empty_o), 32'(1));
        checkOutput("async_count", 32'(count_o), 32'(0));
        checkOutput("async_ovr", 32'(ovr_o), 32'(0));
        checkOutput("async_valid", 32'(rd_valid_o), 32'(0));
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        applyStimulus(1, 10'h077, 0, 0, 0);
        checkOutput("post_reset_head", 32'(rd_data_o), 32'h77);
        applyStimulus(0, 10'h000, 1, 0, 0);

        // Randomized traffic, fully checked by the monitor.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, 10'($urandom_range(0, 1023)),
                          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 3);
        end
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 10'h000, 1, 0, 0);
        checkOutput("final_scoreboard_empty", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/is_uart_rx_buf.md
IS_UART_RX_BUF -- requirements
Module: is_uart_rx_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of stored words; power of two, minimum 2.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1: width of count_o.
REQ-003 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data_en_i  input  1  one-cycle strobe from the RX FSM: received word valid.
REQ-006 SHALL have port rx_data_t_i  input  10  received word: [9] frame error, [8] parity error, [7:0] data.
REQ-007 SHALL have port rd_ready_i  input  1  consumer accepts the head word.
REQ-008 SHALL have port rd_valid_o  output  1  head word available.
REQ-009 SHALL have port rd_data_o  output  8  head word data.
REQ-010 SHALL have port rd_perr_o  output  1  head word parity error flag.
REQ-011 SHALL have port rd_ferr_o  output  1  head word frame error flag.
REQ-012 SHALL have port count_o  output  CW  number of stored words, 0..DEPTH.
REQ-013 SHALL have port empty_o  output  1  count_o == 0.
REQ-014 SHALL have port full_o  output  1  count_o == DEPTH.
REQ-015 SHALL have port ovr_o  output  1  sticky overrun flag.
REQ-016 SHALL have port ovr_clr_i  input  1  clears ovr_o.
REQ-017 SHALL have port err_cnt_o  output  8  saturating count of received words with any error bit set.
REQ-018 SHALL have port err_clr_i  input  1  clears err_cnt_o.

Function
REQ-019 SHALL behave as a show-ahead FIFO: while rd_valid_o=1, rd_data_o/rd_perr_o/rd_ferr_o present the oldest stored word.
REQ-020 rd_valid_o SHALL equal ~empty_o; outputs other than rd_valid_o are don't-care while rd_valid_o=0.
REQ-021 Pop SHALL occur in a cycle with rd_valid_o=1 and rd_ready_i=1; next head visible the following cycle.
REQ-022 Push SHALL occur when rx_data_en_i=1 and (full_o=0 or pop in same cycle); word stored with all 10 bits.
REQ-023 Write-to-read latency: word pushed into empty buffer at edge N SHALL give rd_valid_o=1 after edge N; no same-cycle bypass.
REQ-024 Push and pop in same cycle SHALL leave count_o unchanged, including when full (no overrun) and when count=1.
REQ-025 Push with full_o=1 and no pop SHALL drop the word, leave storage/pointers/count unchanged, set ovr_o from the next cycle.
REQ-026 Pop with empty_o=1 SHALL be impossible (gated by rd_valid_o); rd_ready_i while empty has no effect.
REQ-027 Read/write pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0; count_o tracked separately or derived, always 0..DEPTH.
REQ-028 count_o, empty_o, full_o SHALL be registered state updated on the same edge as push/pop.
REQ-029 ovr_o SHALL clear on ovr_clr_i=1; overrun and ovr_clr_i in same cycle: ovr_o=1 (set wins).
REQ-030 err_cnt_o SHALL increment on every rx_data_en_i=1 with rx_data_t_i[9] or [8] set, including dropped words; saturates at 255.
REQ-031 err_clr_i=1 SHALL set err_cnt_o to 0; clear and increment same cycle: 0 (clear wins).
REQ-032 rx_data_en_i is assumed a single-cycle pulse per word; back-to-back strobes SHALL each be handled as independent pushes.

Reset
REQ-033 rstn_i=0 SHALL asynchronously force: pointers 0, count_o=0, empty_o=1, full_o=0, rd_valid_o=0, ovr_o=0, err_cnt_o=0.
REQ-034 Storage array need not be reset; rd_data_o/rd_perr_o/rd_ferr_o are don't-care after reset until first push.
REQ-035 Reset asserted mid-operation SHALL discard all stored words; first push after release appears as head.

Verification
REQ-036 Reset, push 0x0A5 then 0x13C, rd_ready_i=0 -> count_o=2, head data=0xA5 perr=0 ferr=0; pop -> head data=0x3C, perr=1, ferr=0.
REQ-037 DEPTH=8: push 9 words 0x00..0x08 with no pops -> full_o=1 after 8th, ovr_o=1 after 9th, pops return 0x00..0x07, 0x08 lost.
REQ-038 Full buffer, simultaneous push 0x55 and pop -> count_o stays 8, ovr_o stays 0, 0x55 read out last after draining.
REQ-039 Empty buffer, push 0x0FF with rd_ready_i=1 held -> rd_valid_o=1 for exactly one cycle after edge, count_o returns to 0.
REQ-040 Push 300 words alternating bit9/bit8 set with continuous pops -> err_cnt_o=255 (saturated); err_clr_i with concurrent error strobe -> err_cnt_o=0.
REQ-041 Push 20 words with continuous pops (pointer wrap), assert rstn_i=0 with 3 words stored -> empty_o=1, count_o=0 immediately, ovr_o=0.
